// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC, the NOP used when nothing is
// presented to decode, and the {pc, inst} record held in the instruction queue.
package inst_fetch_unit_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_inst_fifo.sv
// Synchronous FIFO with push/pop/clear and an occupancy count. The element type
// is a parameter so the same block serves the instruction queue and PC tracking.
module inst_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  T                           wdata,
  output T                           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; the count qualifies
  // every read, so stale contents are never observed and the array can map
  // onto plain registers or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: issues sequential in-order fetches, pairs each response
// with its PC, queues {pc, inst} for decode, and flushes on redirect.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  logic         running;
  logic [63:0]  fetch_pc;
  logic [63:0]  last_pc;
  logic [63:0]  rsp_pc;
  cnt_t         q_count;
  cnt_t         outstanding;
  cnt_t         drop;
  logic [CW:0]  in_use;
  logic         accept;
  logic         keep;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t rsp_entry;

  // Queue slots are reserved at request time, so a kept response always fits.
  assign in_use         = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = running && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign keep      = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign rsp_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  assign id_valid = (q_count != '0);
  assign pop      = id_valid && id_ready;
  assign id_inst  = id_valid ? head.inst : INST_NOP;
  assign id_pc    = id_valid ? head.pc : last_pc;

  // PC of every accepted request; its count doubles as the outstanding counter.
  inst_fifo #(.DEPTH(DEPTH), .T(logic [63:0])) u_pc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (imem_rsp_valid),
    .clear (1'b0),
    .wdata (fetch_pc),
    .rdata (rsp_pc),
    .count (outstanding)
  );

  inst_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (rsp_entry),
    .rdata (head),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running  <= 1'b0;
      fetch_pc <= PC_RESET;
      last_pc  <= PC_RESET;
      drop     <= '0;
    end else begin
      running <= 1'b1;
      if (id_valid) last_pc <= head.pc;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~64'd3;
        // Every request still in flight after this cycle belongs to the old path.
        drop     <= outstanding - cnt_t'(imem_rsp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 64'd4;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

endmodule
